// File: rtl/switchbox_config_loader.sv
// Streams a switch-box configuration into a shadow register word by word,
// range-checks each 5-bit mux-select field, then commits it atomically to config_out.
module switchbox_config_loader #(
   parameter int WORD_WIDTH   = 16,
   parameter int CONFIG_WIDTH = 160
) (
   input  logic                    clock,
   input  logic                    nreset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [WORD_WIDTH-1:0]   data_in,
   input  logic                    data_valid,
   output logic                    data_ready,
   output logic [CONFIG_WIDTH-1:0] config_out,
   output logic                    config_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int NUM_WORDS   = CONFIG_WIDTH / WORD_WIDTH;
   localparam int FIELD_W     = 5;
   localparam int NUM_FIELDS  = CONFIG_WIDTH / FIELD_W;
   localparam int SIDE_FIELDS = 24;
   localparam int SIDE_LIMIT  = 20;
   localparam int LE_LIMIT    = 26;
   localparam int WCW         = $clog2(NUM_WORDS + 1);
   localparam int FCW         = $clog2(NUM_FIELDS);

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, ERROR} state_t;

   state_t                  state, next_state;
   logic [WCW-1:0]          word_cnt;
   logic [FCW-1:0]          field_cnt;
   logic [CONFIG_WIDTH-1:0] shadow;
   logic [FIELD_W-1:0]      cur_field;
   logic [FIELD_W:0]        field_limit;
   logic                    xfer, field_ok, last_word, last_field;

   assign cur_field   = shadow[int'(field_cnt)*FIELD_W +: FIELD_W];
   // First 24 fields drive 20-input side muxes, the rest 26-input LE muxes.
   assign field_limit = (field_cnt < FCW'(SIDE_FIELDS)) ? (FIELD_W+1)'(SIDE_LIMIT)
                                                        : (FIELD_W+1)'(LE_LIMIT);
   assign field_ok    = {1'b0, cur_field} < field_limit;
   assign last_word   = word_cnt == WCW'(NUM_WORDS - 1);
   assign last_field  = field_cnt == FCW'(NUM_FIELDS - 1);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      data_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      xfer       = 1'b0;
      case (state)
         IDLE: if (start) next_state = LOAD;
         LOAD: begin
            data_ready = 1'b1;
            busy       = 1'b1;
            xfer       = data_valid & ~abort;
            if (abort)                  next_state = IDLE;
            else if (xfer && last_word) next_state = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (abort)          next_state = IDLE;
            else if (!field_ok) next_state = ERROR;
            else if (last_field) next_state = COMMIT;
         end
         COMMIT: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         ERROR:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // config_out is loaded on the CHECK->COMMIT edge so the new value is visible
   // in the same cycle as the done pulse.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         word_cnt     <= '0;
         field_cnt    <= '0;
         shadow       <= '0;
         config_out   <= '0;
         config_valid <= 1'b0;
         error        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               word_cnt  <= '0;
               field_cnt <= '0;
               shadow    <= '0;
               error     <= 1'b0;
            end
            LOAD: if (xfer) begin
               shadow[int'(word_cnt)*WORD_WIDTH +: WORD_WIDTH] <= data_in;
               word_cnt <= word_cnt + WCW'(1);
            end
            CHECK: if (!abort) begin
               if (!field_ok) begin
                  error <= 1'b1;
               end else if (last_field) begin
                  config_out   <= shadow;
                  config_valid <= 1'b1;
               end else begin
                  field_cnt <= field_cnt + FCW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_switchbox_config_loader.sv
// Directed bench for switchbox_config_loader: cycle-accurate load, reject,
// stall, abort and async-reset scenarios with hand-computed expectations.
module tb_switchbox_config_loader;

   localparam int W  = 16;
   localparam int CW = 160;

   logic          clock, nreset, start, abort, data_valid;
   logic [W-1:0]  data_in;
   logic          data_ready, config_valid, busy, done, error;
   logic [CW-1:0] config_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [CW-1:0] cfg_a, cfg_19, cfg_20, cfg_le25, cfg_le26, cfg_b, cfg_r, cfg_c;

   switchbox_config_loader #(.WORD_WIDTH(W), .CONFIG_WIDTH(CW)) dut (
      .clock(clock), .nreset(nreset), .start(start), .abort(abort),
      .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
      .config_out(config_out), .config_valid(config_valid), .busy(busy),
      .done(done), .error(error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic begin_load();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Continuous stream of all 10 words; optionally pulse start alongside word start_at.
   task automatic send_words(input logic [CW-1:0] cfg, input int start_at);
      for (int k = 0; k < 10; k++) begin
         data_valid = 1'b1;
         data_in    = cfg[k*W +: W];
         start      = (k == start_at);
         tick();
      end
      data_valid = 1'b0;
      data_in    = '0;
      start      = 1'b0;
   endtask

   task automatic run_commit(input logic [CW-1:0] cfg, input string tag);
      begin_load();
      send_words(cfg, -1);
      wait_cycles(31);
      chk({tag, "_done_c42"}, done, 1'b0);
      tick();
      chk({tag, "_done_c43"}, done, 1'b1);
      chk({tag, "_cfg_c43"}, config_out, cfg);
      chk({tag, "_err_c43"}, error, 1'b0);
      tick();
   endtask

   initial begin
      cfg_a    = 160'h3;
      cfg_19   = 160'h13;
      cfg_20   = 160'h14;
      cfg_le25 = 160'd25 << 120;
      cfg_le26 = 160'd26 << 120;
      cfg_b    = 160'h5;
      cfg_r    = 160'h7;
      cfg_c    = (160'd25 << 155) | 160'h9;

      nreset = 1'b0; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = '0;
      #12;
      chk("rst_cfg", config_out, '0);
      chk("rst_valid", config_valid, 1'b0);
      chk("rst_ready", data_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", error, 1'b0);

      // Clean load; start honoured on first edge after reset release
      @(negedge clock);
      nreset = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      chk("a_busy_c1", busy, 1'b1);
      chk("a_ready_c1", data_ready, 1'b1);
      send_words(cfg_a, -1);
      chk("a_ready_c11", data_ready, 1'b0);
      chk("a_busy_c11", busy, 1'b1);
      wait_cycles(31);
      chk("a_done_c42", done, 1'b0);
      chk("a_cfg_c42", config_out, '0);
      tick();
      chk("a_done_c43", done, 1'b1);
      chk("a_cfg_c43", config_out, cfg_a);
      chk("a_valid_c43", config_valid, 1'b1);
      chk("a_err_c43", error, 1'b0);
      chk("a_busy_c43", busy, 1'b0);
      tick();
      chk("a_done_c44", done, 1'b0);

      // Side-mux boundary: 19 accepted, 20 rejected at CHECK cycle 11
      run_commit(cfg_19, "f19");
      begin_load();
      send_words(cfg_20, -1);
      chk("f20_err_c11", error, 1'b0);
      tick();
      chk("f20_err_c12", error, 1'b1);
      chk("f20_done_c12", done, 1'b0);
      chk("f20_busy_c12", busy, 1'b0);
      chk("f20_cfg_c12", config_out, cfg_19);
      chk("f20_valid_c12", config_valid, 1'b1);
      tick();
      chk("f20_err_sticky", error, 1'b1);
      chk("f20_done_c13", done, 1'b0);
      begin_load();
      chk("f20_err_cleared", error, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", busy, 1'b0);

      // LE-mux boundary on field 24
      run_commit(cfg_le25, "le25");
      begin_load();
      send_words(cfg_le26, -1);
      wait_cycles(24);
      chk("le26_err_c35", error, 1'b0);
      chk("le26_busy_c35", busy, 1'b1);
      tick();
      chk("le26_err_c36", error, 1'b1);
      chk("le26_cfg_c36", config_out, cfg_le25);
      tick();

      // Stalled stream: valid every other cycle, words in odd cycles 1..19
      begin_load();
      for (int k = 0; k < 10; k++) begin
         data_valid = 1'b1;
         data_in    = cfg_a[k*W +: W];
         tick();
         if (k < 9) begin
            data_valid = 1'b0;
            data_in    = 16'hFFFF;
            tick();
         end
      end
      data_valid = 1'b0;
      data_in    = '0;
      chk("stall_ready_c20", data_ready, 1'b0);
      chk("stall_busy_c20", busy, 1'b1);
      wait_cycles(31);
      chk("stall_done_c51", done, 1'b0);
      tick();
      chk("stall_done_c52", done, 1'b1);
      chk("stall_cfg_c52", config_out, cfg_a);
      tick();

      // Abort in LOAD, coinciding with a transfer
      begin_load();
      for (int k = 0; k < 5; k++) begin
         data_valid = 1'b1;
         data_in    = cfg_b[k*W +: W];
         tick();
      end
      data_in = cfg_b[5*W +: W];
      abort   = 1'b1;
      tick();
      abort = 1'b0; data_valid = 1'b0;
      chk("abl_busy", busy, 1'b0);
      chk("abl_ready", data_ready, 1'b0);
      chk("abl_cfg", config_out, cfg_a);
      chk("abl_valid", config_valid, 1'b1);
      chk("abl_err", error, 1'b0);
      chk("abl_done", done, 1'b0);

      // Abort in CHECK
      begin_load();
      send_words(cfg_b, -1);
      wait_cycles(4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abc_busy", busy, 1'b0);
      wait_cycles(40);
      chk("abc_done", done, 1'b0);
      chk("abc_cfg", config_out, cfg_a);

      // Async reset in CHECK cycle 20
      begin_load();
      send_words(cfg_r, -1);
      wait_cycles(9);
      #2 nreset = 1'b0;
      #1;
      chk("ar_cfg", config_out, '0);
      chk("ar_valid", config_valid, 1'b0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_ready", data_ready, 1'b0);
      chk("ar_done", done, 1'b0);
      chk("ar_err", error, 1'b0);
      @(negedge clock);
      nreset = 1'b1;
      wait_cycles(3);
      chk("ar_needs_start", busy, 1'b0);

      // Reload after reset; start pulsed mid-LOAD must be ignored
      begin_load();
      send_words(cfg_c, 4);
      wait_cycles(31);
      chk("c_done_c42", done, 1'b0);
      tick();
      chk("c_done_c43", done, 1'b1);
      chk("c_cfg_c43", config_out, cfg_c);
      chk("c_valid_c43", config_valid, 1'b1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
